fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the decoder and alongside `program_counter`. It reads the current PC, issues word reads to instruction memory over a request/acknowledge handshake, and steps the PC with a one-cycle increment pulse per accepted word. Fetched words are buffered with their addresses in a small FIFO that feeds the decoder through a valid/ready handshake. Execute-stage redirects (jumps and branches) are forwarded to the PC as a jump, and any stale or in-flight fetches are discarded.

---
 rtl/fetch_unit.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Reads the current PC, issues word reads
//             to instruction memory over a request/acknowledge handshake, and
//             pulses pc_inc once per accepted word. Fetched words are queued
//             with their addresses and presented to the decoder through a
//             valid/ready handshake. Execute-stage redirects are forwarded to
//             the PC as a jump; stale or in-flight fetches are discarded.
//
//  Parameters
//    DEPTH          instruction queue entries (power of two, >= 2)
//
//  Ports
//    clock          sole clock, rising edge
//    reset          asynchronous, active-high
//    pc_data        current PC value
//    pc_inc         increment PC by 4 at this edge (combinational)
//    pc_jump        load PC with pc_jump_data at this edge (= redirect)
//    pc_jump_data   jump target (= redirect_addr)
//    redirect       execute-stage redirect request
//    redirect_addr  redirect target
//    mem_read       memory read request (registered)
//    mem_addr       memory request address (registered, word aligned)
//    mem_ack        memory read data valid this cycle
//    mem_data       memory read data
//    instr_valid    queue head valid
//    instr_ready    decoder accepts the head
//    instr_data     head instruction word (0 when empty)
//    instr_pc       head instruction address (0 when empty)
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_data,
    output logic        pc_inc,
    output logic        pc_jump,
    output logic [31:0] pc_jump_data,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    // IDLE    : no request outstanding
    // REQ     : request outstanding, returned data is kept
    // DISCARD : request outstanding, returned data is dropped
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_mem_read;
    logic [31:0]          r_mem_addr;
    logic [31:0]          w_mem_addr_nxt;

    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [31:0]          r_q_data [DEPTH];
    logic [31:0]          r_q_pc   [DEPTH];

    logic                 w_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [c_CNT_W-1:0]   w_count_post;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & instr_ready;
    // A returned word is only kept when the request is live and no redirect
    // is invalidating it in the same cycle.
    assign w_push  = (r_state == S_REQ) & mem_ack & ~redirect;

    // Occupancy after this edge assuming a push; decides whether the next
    // sequential fetch can be launched back-to-back. A push only happens in
    // REQ, which is entered only with space available, so this never
    // overflows c_CNT_W bits.
    assign w_count_post = r_count + c_CNT_W'(1) - c_CNT_W'(w_pop);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mem_read <= 1'b0;
            r_mem_addr <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            // mem_read is a pure function of the next state, registered so
            // that no combinational path exists from decoder or memory
            // inputs to the request line.
            r_mem_read <= (w_state_nxt != S_IDLE);
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and request address
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            S_IDLE: begin
                // Launch is based on current occupancy only; a same-cycle pop
                // frees its slot for the following cycle.
                if (!redirect && (r_count < c_DEPTH)) begin
                    w_state_nxt    = S_REQ;
                    w_mem_addr_nxt = pc_data;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    // The outstanding request cannot be withdrawn; if it has
                    // not completed yet, its data must be swallowed later.
                    w_state_nxt = mem_ack ? S_IDLE : S_DISCARD;
                end else if (mem_ack) begin
                    if (w_count_post < c_DEPTH) begin
                        // Wraps naturally from 0xFFFFFFFC to 0x00000000.
                        w_mem_addr_nxt = r_mem_addr + 32'd4;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Instruction queue: pointers and occupancy
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect) begin
            // Flush wins over any same-cycle push or pop.
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= mem_data;
            r_q_pc[r_wr_ptr]   <= r_mem_addr;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc_inc       = w_push;
    assign pc_jump      = redirect;
    assign pc_jump_data = redirect_addr;
    assign mem_read     = r_mem_read;
    assign mem_addr     = r_mem_addr;
    assign instr_valid  = w_valid;
    assign instr_data   = w_valid ? r_q_data[r_rd_ptr] : 32'd0;
    assign instr_pc     = w_valid ? r_q_pc[r_rd_ptr]   : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A queue-based behavioural
//             model tracks the expected outputs every cycle; directed
//             scenarios add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    logic [31:0] pc_data;
    logic        pc_inc;
    logic        pc_jump;
    logic [31:0] pc_jump_data;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_data       (pc_data),
        .pc_inc        (pc_inc),
        .pc_jump       (pc_jump),
        .pc_jump_data  (pc_jump_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Program counter: plain register driven by the DUT's inc/jump requests.
    // ------------------------------------------------------------------------
    initial pc_data = 32'd0;
    always @(posedge clock or posedge reset) begin
        if (reset)        pc_data <= 32'd0;
        else if (pc_jump) pc_data <= pc_jump_data;
        else if (pc_inc)  pc_data <= pc_data + 32'd4;
    end

    // ------------------------------------------------------------------------
    // Memory: acks a request after mem_lat waiting cycles, data = addr^A5A5A5A5
    // unless a one-shot override word is armed.
    // ------------------------------------------------------------------------
    int          mem_lat   = 0;
    int          wcnt      = 0;
    bit          prev_read = 0;
    bit          prev_ack  = 0;
    bit          ovr_en    = 0;
    logic [31:0] ovr_data  = 32'd0;

    task automatic drive_mem();
        if (reset) begin
            wcnt = 0; prev_read = 0; prev_ack = 0;
            mem_ack = 1'b0; mem_data = 32'd0;
        end else begin
            if (prev_read && !prev_ack) wcnt++;
            else                        wcnt = 0;
            mem_ack = mem_read && (wcnt >= mem_lat);
            if (mem_ack && ovr_en) begin
                mem_data = ovr_data;
                ovr_en   = 0;
            end else begin
                mem_data = mem_addr ^ 32'hA5A5A5A5;
            end
            prev_read = mem_read;
            prev_ack  = mem_ack;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        drive_mem();
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: an outstanding-request flag, a keep/drop flag, the
    // request address and a plain queue of {pc, word}.
    // ------------------------------------------------------------------------
    bit          m_busy = 0;
    bit          m_keep = 0;
    logic [31:0] m_addr = 32'd0;
    logic [63:0] m_q[$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_keep = 0; m_addr = 32'd0;
            m_q.delete();
        end else begin : model_step
            int n;
            bit pop;
            n   = m_q.size();
            pop = (n != 0) && instr_ready;
            if (redirect) begin
                m_q.delete();
                if (m_busy && mem_ack) m_busy = 0;
                else if (m_busy)       m_keep = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (!m_busy) begin
                    if (n < DEPTH) begin
                        m_busy = 1; m_keep = 1; m_addr = pc_data;
                    end
                end else if (mem_ack) begin
                    if (m_keep) begin
                        m_q.push_back({m_addr, mem_data});
                        if (m_q.size() < DEPTH) m_addr = m_addr + 32'd4;
                        else                    m_busy = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare, plus observation logs used by directed checks.
    // ------------------------------------------------------------------------
    logic [31:0] seen_pc[$];
    logic [31:0] seen_data[$];
    int          n_acks  = 0;
    bit          saw_bad = 0;

    always @(negedge clock) begin : compare
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_inc;
        e_valid = (m_q.size() != 0);
        e_data  = 32'd0;
        e_pc    = 32'd0;
        if (e_valid) begin
            e_data = m_q[0][31:0];
            e_pc   = m_q[0][63:32];
        end
        e_inc = m_busy && m_keep && mem_ack && !redirect;
        chk("mem_read",     32'(mem_read),    32'(m_busy));
        chk("mem_addr",     mem_addr,         m_addr);
        chk("instr_valid",  32'(instr_valid), 32'(e_valid));
        chk("instr_data",   instr_data,       e_data);
        chk("instr_pc",     instr_pc,         e_pc);
        chk("pc_inc",       32'(pc_inc),      32'(e_inc));
        chk("pc_jump",      32'(pc_jump),     32'(redirect));
        chk("pc_jump_data", pc_jump_data,     redirect_addr);
        if (instr_valid && instr_ready) begin
            seen_pc.push_back(instr_pc);
            seen_data.push_back(instr_data);
        end
        if (instr_valid && (instr_data == 32'hDEADBEEF)) saw_bad = 1;
        if (mem_read && mem_ack) n_acks++;
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    logic [31:0] exp_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_word [4] = '{32'hA5A5A5A5, 32'hA5A5A5A1, 32'hA5A5A5AD, 32'hA5A5A5A9};

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 32'd0;
        instr_ready   = 1'b1;
        mem_ack       = 1'b0;
        mem_data      = 32'd0;

        // Reset state
        step();
        settle();
        chk("rst_read",  32'(mem_read),    32'd0);
        chk("rst_addr",  mem_addr,         32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_inc",   32'(pc_inc),      32'd0);

        // Streaming, zero-wait memory, decoder always ready
        reset_dut();
        seen_pc.delete();
        seen_data.delete();
        settle();
        chk("first_read_c0", 32'(mem_read), 32'd0);
        step();
        settle();
        chk("first_read_c1", 32'(mem_read), 32'd1);
        repeat (7) step();
        chk("stream_count", 32'(seen_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("stream_pc",   (i < seen_pc.size())   ? seen_pc[i]   : 32'hFFFFFFFF, exp_pc[i]);
            chk("stream_data", (i < seen_data.size()) ? seen_data[i] : 32'hFFFFFFFF, exp_word[i]);
        end

        // Back-pressure: queue fills with two words, fetching stops
        instr_ready = 1'b0;
        reset_dut();
        n_acks = 0;
        repeat (8) step();
        settle();
        chk("bp_acks",  32'(n_acks),      32'd2);
        chk("bp_read",  32'(mem_read),    32'd0);
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_head",  instr_pc,         32'h0);
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        repeat (6) step();
        settle();
        chk("bp_acks2", 32'(n_acks),      32'd3);
        chk("bp_read2", 32'(mem_read),    32'd0);
        chk("bp_valid2",32'(instr_valid), 32'd1);
        chk("bp_head2", instr_pc,         32'h4);

        // Redirect while a request waits; its late data must be dropped
        instr_ready = 1'b1;
        mem_lat     = 3;
        reset_dut();
        saw_bad = 0;
        step();
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        ovr_data      = 32'hDEADBEEF;
        ovr_en        = 1;
        settle();
        chk("rd_jump", 32'(pc_jump), 32'd1);
        step();
        redirect = 1'b0;
        repeat (3) step();
        settle();
        chk("rd_empty", 32'(instr_valid), 32'd0);
        chk("rd_idle",  32'(mem_read),    32'd0);
        step();
        settle();
        chk("rd_read", 32'(mem_read), 32'd1);
        chk("rd_addr", mem_addr,      32'h100);
        mem_lat = 0;

        // Redirect coinciding with an ack and a pop
        repeat (5) step();
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        settle();
        chk("rap_inc",   32'(pc_inc),      32'd0);
        chk("rap_jump",  32'(pc_jump),     32'd1);
        chk("rap_valid", 32'(instr_valid), 32'd1);
        step();
        redirect = 1'b0;
        settle();
        chk("rap_flush", 32'(instr_valid), 32'd0);
        chk("rap_idle",  32'(mem_read),    32'd0);
        step();
        settle();
        chk("rap_read", 32'(mem_read), 32'd1);
        chk("rap_addr", mem_addr,      32'h200);
        chk("never_deadbeef", 32'(saw_bad), 32'd0);

        // Address wrap
        step();
        redirect      = 1'b1;
        redirect_addr = 32'hFFFFFFF8;
        step();
        redirect = 1'b0;
        step();
        step();
        settle();
        chk("wrap_fc", mem_addr, 32'hFFFFFFFC);
        step();
        settle();
        chk("wrap_addr", mem_addr,      32'h0);
        chk("wrap_read", 32'(mem_read), 32'd1);

        // Asynchronous reset mid-request with a non-empty queue
        mem_lat = 5;
        step();
        instr_ready = 1'b0;
        step();
        settle();
        chk("ar_pre_read",  32'(mem_read),    32'd1);
        chk("ar_pre_valid", 32'(instr_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_read",  32'(mem_read),    32'd0);
        chk("ar_addr",  mem_addr,         32'd0);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_data",  instr_data,       32'd0);
        chk("ar_pc",    instr_pc,         32'd0);
        chk("ar_inc",   32'(pc_inc),      32'd0);
        chk("ar_jump",  32'(pc_jump),     32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
